// File: rtl/pic_alu_pkg.sv
// Shared definitions for the PIC-style sequential ALU: op codes, status flag
// positions and the controller state encoding.
package pic_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_IOR  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_COM  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_CLR  = 4'h9;
    localparam logic [3:0] OP_SWAP = 4'hA;
    localparam logic [3:0] OP_RLF  = 4'hB;
    localparam logic [3:0] OP_RRF  = 4'hC;
    localparam logic [3:0] OP_BCF  = 4'hD;
    localparam logic [3:0] OP_BSF  = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_DC = 1;
    localparam int unsigned FLAG_C  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Replace only the flag bits selected by mask.
    function automatic logic [2:0] merge_flags(input logic [2:0] cur,
                                               input logic [2:0] nxt,
                                               input logic [2:0] mask);
        return (cur & ~mask) | (nxt & mask);
    endfunction

endpackage

// File: rtl/pic_alu_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per clock. The first step
// is taken on the start edge, so done is high the cycle after the last step.
module pic_alu_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_mc, src_hi, src_lo;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    cnt_nxt;

    always_comb begin : step_comb
        src_mc  = start ? a : mcand_q;
        src_hi  = start ? '0 : hi_q;
        src_lo  = start ? b : lo_q;
        sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : '0);
        cnt_nxt = start ? CW'(1) : cnt_q + CW'(1);

        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Partial sum shifts right into the vacated multiplier bits.
        if (start || busy_q) begin
            mcand_d = src_mc;
            hi_d    = sum[WIDTH:1];
            lo_d    = {sum[0], src_lo[WIDTH-1:1]};
            cnt_d   = cnt_nxt;
            busy_d  = (cnt_nxt != CW'(WIDTH));
            done_d  = (cnt_nxt == CW'(WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin : step_regs
        if (rst) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign prod = {hi_q, lo_q};

endmodule

// File: rtl/pic_alu_seq.sv
// PIC-style ALU with a valid/ready request side, a held result side and a
// Z/DC/C status register; MUL runs through the iterative multiplier.
module pic_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 op,
    input  logic [WIDTH-1:0]           w_bus,
    input  logic [WIDTH-1:0]           f_bus,
    input  logic [$clog2(WIDTH)-1:0]   bit_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           alu_bus,
    output logic [WIDTH-1:0]           alu_hi,
    output logic [2:0]                 status,
    input  logic                       status_we,
    input  logic [2:0]                 status_in
);
    import pic_alu_pkg::*;

    localparam int unsigned HW = WIDTH / 2;

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("pic_alu_seq: WIDTH must be even and at least 4");
    end

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_bus_q, alu_bus_d;
    logic [WIDTH-1:0] alu_hi_q, alu_hi_d;
    logic [2:0]       status_q, status_d;

    logic               accept_c;
    logic               mul_start_c;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   add_w, sub_w;
    logic [4:0]       add_n, sub_n;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] sc_res;
    logic [2:0]       sc_flags, sc_mask;
    logic             c_in;

    pic_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start_c),
        .a     (w_bus),
        .b     (f_bus),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Single-cycle datapath, evaluated on the request inputs at accept.
    always_comb begin : alu_comb
        c_in     = status_q[FLAG_C];
        add_w    = {1'b0, f_bus} + {1'b0, w_bus};
        sub_w    = {1'b0, f_bus} - {1'b0, w_bus};
        add_n    = {1'b0, f_bus[3:0]} + {1'b0, w_bus[3:0]};
        sub_n    = {1'b0, f_bus[3:0]} - {1'b0, w_bus[3:0]};
        bit_mask = WIDTH'(1) << bit_sel;
        sc_res   = f_bus;
        sc_flags = 3'b000;
        sc_mask  = 3'b000;
        case (op)
            OP_ADD: begin
                sc_res           = add_w[WIDTH-1:0];
                sc_flags[FLAG_C] = add_w[WIDTH];
                sc_flags[FLAG_DC] = add_n[4];
                sc_mask          = 3'b111;
            end
            OP_SUB: begin
                sc_res           = sub_w[WIDTH-1:0];
                sc_flags[FLAG_C] = ~sub_w[WIDTH];
                sc_flags[FLAG_DC] = ~sub_n[4];
                sc_mask          = 3'b111;
            end
            OP_AND:  begin sc_res = f_bus & w_bus;      sc_mask[FLAG_Z] = 1'b1; end
            OP_IOR:  begin sc_res = f_bus | w_bus;      sc_mask[FLAG_Z] = 1'b1; end
            OP_XOR:  begin sc_res = f_bus ^ w_bus;      sc_mask[FLAG_Z] = 1'b1; end
            OP_COM:  begin sc_res = ~f_bus;             sc_mask[FLAG_Z] = 1'b1; end
            OP_INC:  begin sc_res = f_bus + WIDTH'(1);  sc_mask[FLAG_Z] = 1'b1; end
            OP_DEC:  begin sc_res = f_bus - WIDTH'(1);  sc_mask[FLAG_Z] = 1'b1; end
            OP_MOV:  begin sc_res = f_bus;              sc_mask[FLAG_Z] = 1'b1; end
            OP_CLR:  begin sc_res = '0;                 sc_mask[FLAG_Z] = 1'b1; end
            OP_SWAP: sc_res = {f_bus[HW-1:0], f_bus[WIDTH-1:HW]};
            OP_RLF: begin
                sc_res           = {f_bus[WIDTH-2:0], c_in};
                sc_flags[FLAG_C] = f_bus[WIDTH-1];
                sc_mask[FLAG_C]  = 1'b1;
            end
            OP_RRF: begin
                sc_res           = {c_in, f_bus[WIDTH-1:1]};
                sc_flags[FLAG_C] = f_bus[0];
                sc_mask[FLAG_C]  = 1'b1;
            end
            OP_BCF:  sc_res = f_bus & ~bit_mask;
            OP_BSF:  sc_res = f_bus | bit_mask;
            default: ;
        endcase
        sc_flags[FLAG_Z] = (sc_res == '0);
    end

    always_comb begin : ctrl_comb
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_bus_d   = alu_bus_q;
        alu_hi_d    = alu_hi_q;
        status_d    = status_q;
        mul_start_c = 1'b0;
        accept_c    = in_valid & in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (op == OP_MUL) begin
                        state_d     = ST_MUL;
                        mul_start_c = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        alu_bus_d   = sc_res;
                        alu_hi_d    = '0;
                        status_d    = merge_flags(status_q, sc_flags, sc_mask);
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d          = ST_DONE;
                    out_valid_d      = 1'b1;
                    alu_bus_d        = mul_prod[WIDTH-1:0];
                    alu_hi_d         = mul_prod[2*WIDTH-1:WIDTH];
                    status_d[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
                    status_d[FLAG_Z] = ~|mul_prod;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A direct status load overrides any flag update in the same cycle.
        if (status_we) begin
            status_d = status_in;
        end
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin : ctrl_regs
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_bus_q   <= '0;
            alu_hi_q    <= '0;
            status_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            alu_bus_q   <= alu_bus_d;
            alu_hi_q    <= alu_hi_d;
            status_q    <= status_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_bus   = alu_bus_q;
    assign alu_hi    = alu_hi_q;
    assign status    = status_q;

endmodule

// File: tb/tb_pic_alu_seq.sv
// Directed bench for pic_alu_seq: vector table for single-cycle ops plus
// hand sequences for MUL latency, DONE stalls, mid-MUL reset and WIDTH=16.
module tb_pic_alu_seq;
    import pic_alu_pkg::*;

    logic clk;
    logic rst;

    logic       iv8, ir8, ov8, ordy8, swe8;
    logic [3:0] op8;
    logic [7:0] w8, f8, alu8, hi8;
    logic [2:0] bs8, st8, sin8;

    logic        iv16, ir16, ov16, ordy16, swe16;
    logic [3:0]  op16;
    logic [15:0] w16, f16, alu16, hi16;
    logic [3:0]  bs16;
    logic [2:0]  st16, sin16;

    int checks;
    int failures;

    pic_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .w_bus(w8), .f_bus(f8), .bit_sel(bs8), .out_valid(ov8),
        .out_ready(ordy8), .alu_bus(alu8), .alu_hi(hi8), .status(st8),
        .status_we(swe8), .status_in(sin8)
    );

    pic_alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .w_bus(w16), .f_bus(f16), .bit_sel(bs16), .out_valid(ov16),
        .out_ready(ordy16), .alu_bus(alu16), .alu_hi(hi16), .status(st16),
        .status_we(swe16), .status_in(sin16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] w;
        logic [7:0] f;
        logic [2:0] bs;
        logic [2:0] pre;
        logic [7:0] res;
        logic [2:0] st;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic start_op8(input logic [3:0] o, input logic [7:0] w, input logic [7:0] f,
                             input logic [2:0] bs, input logic we, input logic [2:0] si);
        op8 = o; w8 = w; f8 = f; bs8 = bs; iv8 = 1'b1; swe8 = we; sin8 = si;
        tick();
        iv8 = 1'b0; swe8 = 1'b0;
    endtask

    task automatic finish_op8();
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
    endtask

    task automatic load_status8(input logic [2:0] s);
        swe8 = 1'b1; sin8 = s;
        tick();
        swe8 = 1'b0;
    endtask

    task automatic run_mul8(input string name, input logic [7:0] w, input logic [7:0] f,
                            input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                            input logic [2:0] pre, input logic [2:0] exp_st);
        int lat;
        bit seen_rdy;
        load_status8(pre);
        start_op8(OP_MUL, w, f, 3'd0, 1'b0, 3'b000);
        lat = 1;
        seen_rdy = 1'b0;
        while (ov8 !== 1'b1 && lat < 30) begin
            if (ir8 !== 1'b0) seen_rdy = 1'b1;
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd9);
        chk({name, "_ready_low"}, {31'd0, seen_rdy | ir8}, 32'd0);
        chk({name, "_lo"}, {24'd0, alu8}, {24'd0, exp_lo});
        chk({name, "_hi"}, {24'd0, hi8}, {24'd0, exp_hi});
        chk({name, "_status"}, {29'd0, st8}, {29'd0, exp_st});
        finish_op8();
    endtask

    initial begin
        int stable;
        bit seen_ov;

        checks = 0; failures = 0;
        rst = 1'b1;
        iv8 = 0; op8 = 0; w8 = 0; f8 = 0; bs8 = 0; ordy8 = 0; swe8 = 0; sin8 = 0;
        iv16 = 0; op16 = 0; w16 = 0; f16 = 0; bs16 = 0; ordy16 = 0; swe16 = 0; sin16 = 0;

        //           op       w      f      bs    pre     res    st{Z,DC,C}
        vecs[0]  = '{OP_ADD,  8'hF0, 8'h16, 3'd0, 3'b000, 8'h06, 3'b001};
        vecs[1]  = '{OP_SUB,  8'h05, 8'h05, 3'd0, 3'b000, 8'h00, 3'b111};
        vecs[2]  = '{OP_SUB,  8'h06, 8'h05, 3'd0, 3'b111, 8'hFF, 3'b000};
        vecs[3]  = '{OP_RLF,  8'h00, 8'h80, 3'd0, 3'b001, 8'h01, 3'b001};
        vecs[4]  = '{OP_SWAP, 8'h00, 8'hA5, 3'd0, 3'b110, 8'h5A, 3'b110};
        vecs[5]  = '{OP_AND,  8'h0F, 8'hF0, 3'd0, 3'b000, 8'h00, 3'b100};
        vecs[6]  = '{OP_IOR,  8'h0F, 8'h30, 3'd0, 3'b111, 8'h3F, 3'b011};
        vecs[7]  = '{OP_XOR,  8'hFF, 8'hFF, 3'd0, 3'b011, 8'h00, 3'b111};
        vecs[8]  = '{OP_COM,  8'h00, 8'h00, 3'd0, 3'b100, 8'hFF, 3'b000};
        vecs[9]  = '{OP_INC,  8'h00, 8'hFF, 3'd0, 3'b011, 8'h00, 3'b111};
        vecs[10] = '{OP_DEC,  8'h00, 8'h00, 3'd0, 3'b100, 8'hFF, 3'b000};
        vecs[11] = '{OP_MOV,  8'h12, 8'h00, 3'd0, 3'b000, 8'h00, 3'b100};
        vecs[12] = '{OP_CLR,  8'h00, 8'h55, 3'd0, 3'b011, 8'h00, 3'b111};
        vecs[13] = '{OP_RRF,  8'h00, 8'h01, 3'd0, 3'b000, 8'h00, 3'b001};
        vecs[14] = '{OP_BCF,  8'h00, 8'hFF, 3'd3, 3'b101, 8'hF7, 3'b101};
        vecs[15] = '{OP_BSF,  8'h00, 8'h00, 3'd7, 3'b010, 8'h80, 3'b010};
        vecs[16] = '{OP_ADD,  8'h0F, 8'h01, 3'd0, 3'b000, 8'h10, 3'b010};
        vecs[17] = '{OP_ADD,  8'hFF, 8'h01, 3'd0, 3'b000, 8'h00, 3'b111};

        #2;
        chk("rst_in_ready", {31'd0, ir8}, 32'd1);
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_alu_bus", {24'd0, alu8}, 32'd0);
        chk("rst_alu_hi", {24'd0, hi8}, 32'd0);
        chk("rst_status", {29'd0, st8}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            load_status8(vecs[i].pre);
            start_op8(vecs[i].op, vecs[i].w, vecs[i].f, vecs[i].bs, 1'b0, 3'b000);
            chk($sformatf("v%0d_out_valid", i), {31'd0, ov8}, 32'd1);
            chk($sformatf("v%0d_alu_bus", i), {24'd0, alu8}, {24'd0, vecs[i].res});
            chk($sformatf("v%0d_alu_hi", i), {24'd0, hi8}, 32'd0);
            chk($sformatf("v%0d_status", i), {29'd0, st8}, {29'd0, vecs[i].st});
            finish_op8();
            chk($sformatf("v%0d_back_idle", i), {30'd0, ir8, ov8}, 32'd2);
        end

        run_mul8("mul_ffff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 3'b000, 3'b001);
        run_mul8("mul_zero", 8'h00, 8'h37, 8'h00, 8'h00, 3'b011, 3'b110);
        run_mul8("mul_small", 8'h0C, 8'h0A, 8'h78, 8'h00, 3'b111, 3'b010);

        // Hold the result in DONE while a second request is offered.
        start_op8(OP_ADD, 8'h01, 8'h02, 3'd0, 1'b0, 3'b000);
        iv8 = 1'b1; op8 = OP_CLR; f8 = 8'h55;
        stable = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ov8 === 1'b1 && ir8 === 1'b0 && alu8 === 8'h03) stable++;
        end
        chk("stall_stable_cycles", 32'(stable), 32'd5);
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0; iv8 = 1'b0;
        chk("stall_release", {30'd0, ir8, ov8}, 32'd2);
        tick();
        chk("stall_not_queued_valid", {31'd0, ov8}, 32'd0);
        chk("stall_not_queued_bus", {24'd0, alu8}, 32'h03);

        // Reset during the third MUL cycle abandons the product.
        load_status8(3'b011);
        start_op8(OP_MUL, 8'hFF, 8'hFF, 3'd0, 1'b0, 3'b000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mulrst_in_ready", {31'd0, ir8}, 32'd1);
        chk("mulrst_status", {29'd0, st8}, 32'd0);
        chk("mulrst_alu_bus", {24'd0, alu8}, 32'd0);
        tick();
        rst = 1'b0;
        seen_ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (ov8 !== 1'b0) seen_ov = 1'b1;
            tick();
        end
        chk("mulrst_no_valid", {31'd0, seen_ov}, 32'd0);
        chk("mulrst_status_after", {29'd0, st8}, 32'd0);
        chk("mulrst_hi_after", {24'd0, hi8}, 32'd0);

        // Direct status load coinciding with the commit edge wins.
        start_op8(OP_ADD, 8'hF0, 8'h16, 3'd0, 1'b1, 3'b101);
        chk("we_commit_bus", {24'd0, alu8}, 32'h06);
        chk("we_commit_status", {29'd0, st8}, 32'h5);
        finish_op8();

        // WIDTH=16 instance.
        op16 = OP_ADD; w16 = 16'hF000; f16 = 16'h1600; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        chk("w16_add_valid", {31'd0, ov16}, 32'd1);
        chk("w16_add_bus", {16'd0, alu16}, 32'h0600);
        chk("w16_add_status", {29'd0, st16}, 32'h1);
        ordy16 = 1'b1; tick(); ordy16 = 1'b0;

        w16 = 16'h00FF; f16 = 16'h0001; iv16 = 1'b1; swe16 = 1'b1; sin16 = 3'b101;
        tick();
        iv16 = 1'b0; swe16 = 1'b0;
        chk("w16_we_bus", {16'd0, alu16}, 32'h0100);
        chk("w16_we_status", {29'd0, st16}, 32'h5);
        ordy16 = 1'b1; tick(); ordy16 = 1'b0;

        iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        chk("w16_dc_status", {29'd0, st16}, 32'h2);
        chk("w16_dc_hi", {16'd0, hi16}, 32'd0);
        ordy16 = 1'b1; tick(); ordy16 = 1'b0;
        chk("w16_back_idle", {30'd0, ir16, ov16}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
